mkgauss_collect: RTL

Downstream consumer of the MKGAUSS sampler in the Falcon key-generation datapath. Collects one polynomial of N = 2^LOGN small Gaussian coefficients from the `val` stream. Out-of-range samples are discarded and replaced by the next valid sample. Accumulates the squared norm, decides accept/reject against a bound, and on accept streams the stored coefficients to the next stage over a valid/ready handshake.

---
 rtl/mkgauss_collect.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mkgauss_collect.sv
// Collects one polynomial of 2^LOGN Gaussian coefficients, checks its squared norm and streams it out.
// Optional feature macro: MKGAUSS_ODD_PARITY_EN (forces odd coefficient-sum parity).
module mkgauss_collect #(
  parameter int LOGN       = 9,
  parameter int COEF_BITS  = 6,
  parameter int NORM_W     = 32,
  parameter int NORM_BOUND = 8411
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       val,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic [NORM_W-1:0] sqnorm,
  output logic [15:0]       discards,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_coef,
  output logic              out_last
);
  localparam int N    = 1 << LOGN;
  localparam int MAXV = (1 << (COEF_BITS-1)) - 1;
  localparam int SQ_W = 2*COEF_BITS;

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DRAIN} state_e;
  state_e state_q, state_d;

  logic [LOGN-1:0]      cnt_q, rd_q;
  logic [NORM_W-1:0]    sqnorm_q, sq_sat;
  logic [15:0]          disc_q;
  logic                 reject_q;
  logic [COEF_BITS-1:0] mem [N];

  logic                        in_range, legal, take, drop, last_idx, rej_now;
  logic signed [COEF_BITS-1:0] coef, rd_coef;
  logic signed [SQ_W-1:0]      coef_x, sq;
  logic [NORM_W:0]             sum;

  assign in_range = ($signed(val) <= MAXV) && ($signed(val) >= -MAXV);
  assign coef     = val[COEF_BITS-1:0];
  assign coef_x   = SQ_W'(coef);
  assign sq       = coef_x * coef_x;
  assign sum      = {1'b0, sqnorm_q} + (NORM_W+1)'($unsigned(sq));
  assign sq_sat   = sum[NORM_W] ? '1 : sum[NORM_W-1:0];
  assign last_idx = (cnt_q == '1);
  assign rej_now  = (sqnorm_q >= NORM_W'(NORM_BOUND));

`ifdef MKGAUSS_ODD_PARITY_EN
  logic parity_q;
  // The final slot only takes a sample that leaves the running LSB parity odd.
  assign legal = in_range && (!last_idx || (parity_q ^ val[0]));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      parity_q <= 1'b0;
    else if (state_q == IDLE && start) parity_q <= 1'b0;
    else if (take)                   parity_q <= parity_q ^ val[0];
`else
  assign legal = in_range;
`endif

  assign take = (state_q == COLLECT) && in_valid && legal;
  assign drop = (state_q == COLLECT) && in_valid && !legal;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (take && last_idx) state_d = CHECK;
      CHECK:   state_d = rej_now ? IDLE : DRAIN;
      DRAIN:   if (out_ready && rd_q == '1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      sqnorm_q <= '0;
      disc_q   <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          cnt_q    <= '0;
          rd_q     <= '0;
          sqnorm_q <= '0;
          disc_q   <= '0;
          reject_q <= 1'b0;
        end
        COLLECT: begin
          if (take) begin
            cnt_q    <= cnt_q + 1'b1;
            sqnorm_q <= sq_sat;
          end
          if (drop && disc_q != '1) disc_q <= disc_q + 1'b1;
        end
        CHECK: begin
          reject_q <= rej_now;
          rd_q     <= '0;
        end
        DRAIN: if (out_ready) rd_q <= rd_q + 1'b1;
        default: ;
      endcase
    end

  // Coefficient store has no reset: contents are don't-care until rewritten.
  always_ff @(posedge clk)
    if (take) mem[cnt_q] <= coef;

  assign rd_coef   = mem[rd_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == CHECK);
  assign reject    = (state_q == CHECK) ? rej_now : reject_q;
  assign sqnorm    = sqnorm_q;
  assign discards  = disc_q;
  assign out_valid = (state_q == DRAIN);
  assign out_coef  = out_valid ? 8'(rd_coef) : 8'h00;
  assign out_last  = out_valid && (rd_q == '1);
endmodule
